// File: rtl/rx_buf_pkg.sv
// Shared defaults and pixel-format helper for the receive frame buffer.
// Latency: none (types/functions only).
// Backpressure: not applicable.
package rx_buf_pkg;

    localparam int PIX_W_DEF  = 12;
    localparam int DEPTH_DEF  = 38400;
    localparam int ADDR_W_DEF = 16;

    // RGB444 -> RGB888: each 4-bit component becomes the high nibble of its byte,
    // with the low nibble forced to F.
    function automatic logic [23:0] rgb444_to_888(input logic [11:0] px);
        return {px[11:8], 4'hF, px[7:4], 4'hF, px[3:0], 4'hF};
    endfunction

endpackage

// File: rtl/rx_buf_chan.sv
// One receive channel: saturating write-address counter, pixel memory, registered read port.
// Latency: write lands on the strobe edge; read data appears one cycle after rd_en_i.
// Backpressure: none; writes past DEPTH are dropped (flagged when RX_FRAME_BUF_OVF_EN is defined).
module rx_buf_chan
    import rx_buf_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              Cclk,
    input  logic              rst,
    input  logic              frame_sync_i,
    input  logic              wr_vld_i,
    input  logic [PIX_W-1:0]  wr_dat_i,
    input  logic              ld_vld_i,
    input  logic [ADDR_W-1:0] ld_add_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_add_i,
    output logic [ADDR_W-1:0] wr_add_o,
    output logic [PIX_W-1:0]  rd_dat_o,
    output logic              ovf_o
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [ADDR_W-1:0] wr_add_q, wr_add_d;
    logic [PIX_W-1:0]  mem_q [DEPTH];
    logic [PIX_W-1:0]  rd_dat_q;
    logic              at_end;
    logic              wr_en;
    logic              rd_ok;

    assign at_end = (wr_add_q == DEPTH_A);
    assign wr_en  = wr_vld_i && !at_end;
    assign rd_ok  = (rd_add_i < DEPTH_A);

    // Address priority: frame sync, saturation at DEPTH, write increment, then load.
    always_comb begin
        wr_add_d = wr_add_q;
        if (frame_sync_i) begin
            wr_add_d = '0;
        end else if (at_end) begin
            wr_add_d = wr_add_q;
        end else if (wr_vld_i) begin
            wr_add_d = wr_add_q + ADDR_W'(1);
        end else if (ld_vld_i) begin
            wr_add_d = (ld_add_i >= DEPTH_A) ? DEPTH_A : ld_add_i;
        end
    end

    // Write-address register.
    always_ff @(posedge Cclk) begin
        if (rst) begin
            wr_add_q <= '0;
        end else begin
            wr_add_q <= wr_add_d;
        end
    end

    // Memory array; contents survive reset.
    always_ff @(posedge Cclk) begin
        if (wr_en) begin
            mem_q[wr_add_q] <= wr_dat_i;
        end
    end

    // Registered read port; a same-cycle write to the same address returns the old word.
    always_ff @(posedge Cclk) begin
        if (rst) begin
            rd_dat_q <= '0;
        end else if (rd_en_i) begin
            rd_dat_q <= rd_ok ? mem_q[rd_add_i] : '0;
        end
    end

`ifdef RX_FRAME_BUF_OVF_EN
    logic ovf_q;

    // Sticky overflow: set by a write attempt at the saturated address.
    always_ff @(posedge Cclk) begin
        if (rst || frame_sync_i) begin
            ovf_q <= 1'b0;
        end else if (wr_vld_i && at_end) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

    assign wr_add_o = wr_add_q;
    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/rx_frame_buf.sv
// Multi-channel receive frame buffer read out as RGB888 video, one channel per line (RX_FRAME_BUF_OVF_EN adds overflow flags).
// Latency: HDMIdata shows a pixel one PixelEn period after its memory read.
// Backpressure: none; writes are taken every cycle and the read side is paced by PixelEn.
module rx_frame_buf
    import rx_buf_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int PIX_W     = PIX_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DIV       = 5,
    parameter int HREP_LOG2 = 3
) (
    input  logic                     Cclk,
    input  logic                     rst,
    input  logic                     FraimSync,
    input  logic [NUM_CH*PIX_W-1:0]  RxData,
    input  logic [NUM_CH-1:0]        RxValid,
    input  logic [NUM_CH*ADDR_W-1:0] RxAdd,
    input  logic [NUM_CH-1:0]        RxAddValid,
    output logic [NUM_CH*ADDR_W-1:0] DEWMadd,
    output logic                     PixelEn,
    input  logic                     HVsync,
    input  logic                     HMemRead,
    output logic [23:0]              HDMIdata,
    output logic [NUM_CH-1:0]        WrOvf
);

    localparam int DIV_W = $clog2(DIV);
    localparam int CNT_W = ADDR_W + HREP_LOG2;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [DIV_W-1:0]  div_q, div_d;
    logic              pix_en_q, pix_en_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [NUM_CH-1:0] sel_q, sel_d;
    logic              hmr_q;
    logic [23:0]       hd_q, hd_d;

    logic              line_end;
    logic [ADDR_W-1:0] rd_off;
    logic [ADDR_W:0]   lin_sum;
    logic [ADDR_W-1:0] lin_add;
    logic [PIX_W-1:0]  ch_dat [NUM_CH];
    logic [PIX_W-1:0]  sel_dat;

    // base + offset serves both as the read address and as the next line base.
    assign line_end = hmr_q && !HMemRead;
    assign rd_off   = ADDR_W'(rd_cnt_q >> HREP_LOG2);
    assign lin_sum  = {1'b0, base_q} + {1'b0, rd_off};
    assign lin_add  = (lin_sum >= DEPTH_X) ? DEPTH_A : lin_sum[ADDR_W-1:0];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        rx_buf_chan #(
            .PIX_W  (PIX_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_chan (
            .Cclk         (Cclk),
            .rst          (rst),
            .frame_sync_i (FraimSync),
            .wr_vld_i     (RxValid[c]),
            .wr_dat_i     (RxData[c*PIX_W +: PIX_W]),
            .ld_vld_i     (RxAddValid[c]),
            .ld_add_i     (RxAdd[c*ADDR_W +: ADDR_W]),
            .rd_en_i      (pix_en_q),
            .rd_add_i     (lin_add),
            .wr_add_o     (DEWMadd[c*ADDR_W +: ADDR_W]),
            .rd_dat_o     (ch_dat[c]),
            .ovf_o        (WrOvf[c])
        );
    end

    // One-hot select: OR together the read data of the selected channel.
    always_comb begin
        sel_dat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel_q[c]) begin
                sel_dat = sel_dat | ch_dat[c];
            end
        end
    end

    // Pixel pacing, line/frame read bookkeeping and output pixel next-state.
    always_comb begin
        div_d    = (div_q == DIV_W'(DIV - 1)) ? '0 : div_q + DIV_W'(1);
        pix_en_d = (div_q == DIV_W'(DIV - 1));
        rd_cnt_d = rd_cnt_q;
        base_d   = base_q;
        sel_d    = sel_q;
        hd_d     = hd_q;
        if (!HVsync) begin
            rd_cnt_d = '0;
            base_d   = '0;
            sel_d    = NUM_CH'(1);
        end else if (line_end) begin
            rd_cnt_d = '0;
            base_d   = lin_add;
            sel_d    = (sel_q << 1) | (sel_q >> (NUM_CH - 1));
        end else if (pix_en_q && HMemRead) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
        if (pix_en_q) begin
            hd_d = HMemRead ? rgb444_to_888(12'(sel_dat)) : 24'h000000;
        end
    end

    // Read-side state registers; reset aborts any line in progress.
    always_ff @(posedge Cclk) begin
        if (rst) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
            rd_cnt_q <= '0;
            base_q   <= '0;
            sel_q    <= NUM_CH'(1);
            hmr_q    <= 1'b0;
            hd_q     <= '0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
            rd_cnt_q <= rd_cnt_d;
            base_q   <= base_d;
            sel_q    <= sel_d;
            hmr_q    <= HMemRead;
            hd_q     <= hd_d;
        end
    end

    assign PixelEn  = pix_en_q;
    assign HDMIdata = hd_q;

endmodule
